// File: rtl/mig_ui_responder.sv
// BRAM-backed stand-in for the MIG 7-series UI port: calibration delay, refresh
// back-pressure, decoupled write command/data pairing and fixed-latency reads.
module mig_ui_responder #(
  parameter int ADDR_W         = 28,
  parameter int DATA_W         = 128,
  parameter int DEPTH_LOG2     = 10,
  parameter int RD_LATENCY     = 4,
  parameter int CALIB_CYCLES   = 16,
  parameter int REFRESH_PERIOD = 256,
  parameter int REFRESH_STALL  = 8
) (
  input  logic                  ui_clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     app_addr,
  input  logic [2:0]            app_cmd,
  input  logic                  app_en,
  output logic                  app_rdy,
  input  logic [DATA_W-1:0]     app_wdf_data,
  input  logic [DATA_W/8-1:0]   app_wdf_mask,
  input  logic                  app_wdf_wren,
  input  logic                  app_wdf_end,
  output logic                  app_wdf_rdy,
  output logic [DATA_W-1:0]     app_rd_data,
  output logic                  app_rd_data_valid,
  output logic                  app_rd_data_end,
  output logic                  init_calib_complete,
  output logic                  cmd_err
);

  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam int BYTES = DATA_W / 8;

  typedef enum logic [1:0] {CALIB, RUN, STALL} state_t;

  state_t                state, state_next;
  logic [31:0]           cnt, cnt_next;

  logic [DEPTH_LOG2-1:0] cmd_idx;
  logic                  cmd_fire, wr_cmd_fire, rd_fire, bad_fire, wdf_fire, commit;
  logic                  wc_valid, wd_valid;
  logic [DEPTH_LOG2-1:0] wc_idx, wr_idx;
  logic [DATA_W-1:0]     wd_data, wr_data;
  logic [BYTES-1:0]      wd_mask, wr_mask;

  logic [DATA_W-1:0]     mem [WORDS];
  logic [RD_LATENCY-1:0] pipe_v;
  logic [DATA_W-1:0]     pipe_d [RD_LATENCY];

  logic                  unused_inputs;
  assign unused_inputs = ^{app_addr[2:0], app_addr[ADDR_W-1:DEPTH_LOG2+3], app_wdf_end};

  always_ff @(posedge ui_clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= CALIB;
      cnt                 <= '0;
      init_calib_complete <= 1'b0;
    end else begin
      state               <= state_next;
      cnt                 <= cnt_next;
      init_calib_complete <= init_calib_complete | (state_next != CALIB);
    end
  end

  // One shared counter times calibration, the refresh interval and the stall.
  always_comb begin
    state_next = state;
    cnt_next   = cnt + 32'd1;
    case (state)
      CALIB: if (cnt == 32'(CALIB_CYCLES - 1)) begin
        state_next = RUN;
        cnt_next   = '0;
      end
      RUN: if (cnt == 32'(REFRESH_PERIOD - 1)) begin
        state_next = STALL;
        cnt_next   = '0;
      end
      STALL: if (cnt == 32'(REFRESH_STALL - 1)) begin
        state_next = RUN;
        cnt_next   = '0;
      end
      default: begin
        state_next = CALIB;
        cnt_next   = '0;
      end
    endcase
  end

  assign app_rdy     = (state == RUN) & ~wc_valid;
  assign app_wdf_rdy = init_calib_complete & ~wd_valid;

  assign cmd_idx     = app_addr[DEPTH_LOG2+2:3];
  assign cmd_fire    = app_en & app_rdy;
  assign wr_cmd_fire = cmd_fire & (app_cmd == 3'b000);
  assign rd_fire     = cmd_fire & (app_cmd == 3'b001);
  assign bad_fire    = cmd_fire & (app_cmd[2:1] != 2'b00);
  assign wdf_fire    = app_wdf_wren & app_wdf_rdy;

  // A write commits as soon as both halves exist, whether buffered or arriving now.
  assign commit  = (wc_valid | wr_cmd_fire) & (wd_valid | wdf_fire);
  assign wr_idx  = wc_valid ? wc_idx  : cmd_idx;
  assign wr_data = wd_valid ? wd_data : app_wdf_data;
  assign wr_mask = wd_valid ? wd_mask : app_wdf_mask;

  always_ff @(posedge ui_clk or negedge reset_n) begin
    if (!reset_n) begin
      wc_valid <= 1'b0;
      wd_valid <= 1'b0;
      cmd_err  <= 1'b0;
      pipe_v   <= '0;
    end else begin
      if (commit)           wc_valid <= 1'b0;
      else if (wr_cmd_fire) wc_valid <= 1'b1;
      if (commit)           wd_valid <= 1'b0;
      else if (wdf_fire)    wd_valid <= 1'b1;
      if (bad_fire)         cmd_err  <= 1'b1;
      pipe_v[0] <= rd_fire;
      for (int i = 1; i < RD_LATENCY; i++) pipe_v[i] <= pipe_v[i-1];
    end
  end

  // Array, buffer payloads and read data pipe carry no reset so they map onto BRAM/SRL.
  always_ff @(posedge ui_clk) begin
    if (wr_cmd_fire && !commit) wc_idx <= cmd_idx;
    if (wdf_fire && !commit) begin
      wd_data <= app_wdf_data;
      wd_mask <= app_wdf_mask;
    end
    if (commit) begin
      for (int b = 0; b < BYTES; b++)
        if (!wr_mask[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
    end
    if (rd_fire) pipe_d[0] <= mem[cmd_idx];
    for (int i = 1; i < RD_LATENCY; i++) pipe_d[i] <= pipe_d[i-1];
  end

  assign app_rd_data_valid = pipe_v[RD_LATENCY-1];
  assign app_rd_data_end   = pipe_v[RD_LATENCY-1];
  assign app_rd_data       = pipe_v[RD_LATENCY-1] ? pipe_d[RD_LATENCY-1] : '0;

endmodule

// File: tb/tb_mig_ui_responder.sv
// Scoreboard bench for mig_ui_responder: directed writes/reads with hand-computed
// results, calibration and refresh timing, illegal commands and mid-flight reset.
module tb_mig_ui_responder;

  localparam int RD_LAT = 4;

  localparam logic [127:0] D0      = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
  localparam logic [127:0] FULL8   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] BEEF    = 128'hAAAA_AAAA_BBBB_BBBB_CCCC_CCCC_DEAD_BEEF;
  localparam logic [127:0] MERGED8 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_DEAD_BEEF;
  localparam logic [127:0] D16     = 128'h1616_1616_0F0F_0F0F_A5A5_A5A5_1234_5678;
  localparam logic [127:0] D24     = 128'h2424_2424_F0F0_F0F0_5A5A_5A5A_8765_4321;
  localparam logic [127:0] DX      = 128'hBADB_ADBA_DBAD_BADB_ADBA_DBAD_BADB_ADBA;

  logic         ui_clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [27:0]  app_addr = '0;
  logic [2:0]   app_cmd = '0;
  logic         app_en = 1'b0;
  logic         app_rdy;
  logic [127:0] app_wdf_data = '0;
  logic [15:0]  app_wdf_mask = '0;
  logic         app_wdf_wren = 1'b0;
  logic         app_wdf_end = 1'b0;
  logic         app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         app_rd_data_end;
  logic         init_calib_complete;
  logic         cmd_err;

  mig_ui_responder dut (
    .ui_clk              (ui_clk),
    .reset_n             (reset_n),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_rdy             (app_rdy),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .app_rd_data_end     (app_rd_data_end),
    .init_calib_complete (init_calib_complete),
    .cmd_err             (cmd_err)
  );

  always #5 ui_clk = ~ui_clk;

  int cyc = 0;
  always @(posedge ui_clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] data;
    int           due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   rel = 0;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Drives a command and/or data beat and holds each until it transfers.
  task automatic applyStimulus(input bit do_cmd, input logic [2:0] cmd, input logic [27:0] addr,
                               input bit do_data, input logic [127:0] data, input logic [15:0] mask,
                               input bit push_exp, input logic [127:0] exp_data, output int acc_cyc);
    bit cmd_pend = do_cmd;
    bit data_pend = do_data;
    int guard = 0;
    acc_cyc      = -1;
    app_en       = do_cmd;
    app_cmd      = cmd;
    app_addr     = addr;
    app_wdf_wren = do_data;
    app_wdf_end  = do_data;
    app_wdf_data = data;
    app_wdf_mask = mask;
    while ((cmd_pend || data_pend) && guard < 400) begin
      @(negedge ui_clk);
      if (cmd_pend && app_rdy) begin
        cmd_pend = 1'b0;
        acc_cyc  = cyc;
        if (push_exp) exp_q.push_back('{exp_data, cyc + RD_LAT});
      end
      if (data_pend && app_wdf_rdy) data_pend = 1'b0;
      @(posedge ui_clk); #1;
      if (!cmd_pend) app_en = 1'b0;
      if (!data_pend) begin
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b0;
      end
      guard++;
    end
    app_en       = 1'b0;
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    checkOutput("handshake_done", {cmd_pend, data_pend}, 2'b00);
  endtask

  task automatic waitCycle();
    @(posedge ui_clk); #1;
  endtask

  task automatic rd(input logic [27:0] addr, input logic [127:0] exp_data, input bit push_exp, output int acc);
    applyStimulus(1'b1, 3'b001, addr, 1'b0, '0, '0, push_exp, exp_data, acc);
  endtask

  task automatic wr(input logic [27:0] addr, input logic [127:0] data, input logic [15:0] mask);
    int acc;
    applyStimulus(1'b1, 3'b000, addr, 1'b1, data, mask, 1'b0, '0, acc);
  endtask

  task automatic waitDrain();
    int g = 0;
    while (exp_q.size() != 0 && g < 50) begin
      waitCycle();
      g++;
    end
    checkOutput("scoreboard_drained", exp_q.size(), 0);
  endtask

  // Called right after reset_n rises: 16 cycles of nothing ready, then everything up.
  task automatic calibCheck();
    for (int k = 0; k <= 16; k++) begin
      @(negedge ui_clk);
      checkOutput($sformatf("calib_cycle%0d", k), {init_calib_complete, app_rdy, app_wdf_rdy},
                  (k == 16) ? 3'b111 : 3'b000);
    end
    waitCycle();
  endtask

  // Monitor: every read strobe is matched against the oldest expected return.
  always @(negedge ui_clk) begin
    if (app_rd_data_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_rd_valid", 1'b1, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("rd_data", app_rd_data, mon_e.data);
        checkOutput("rd_cycle", cyc, mon_e.due);
      end
      checkOutput("rd_data_end", app_rd_data_end, 1'b1);
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      mon_e = exp_q.pop_front();
      checkOutput("rd_missing_at_due", 1'b0, 1'b1);
    end
  end

  initial begin
    #100_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc;
    int a[4];
    bit exp_rdy;

    repeat (3) @(posedge ui_clk);
    @(negedge ui_clk);
    checkOutput("reset_outputs", {app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end,
                                  init_calib_complete, cmd_err}, 6'b0);
    checkOutput("reset_rd_data", app_rd_data, '0);

    waitCycle();
    reset_n = 1'b1;
    rel = cyc;
    calibCheck();

    // Full write, then masked write touching only bytes 0..3, then read back.
    wr(28'h000000, D0, 16'h0000);
    wr(28'h000008, FULL8, 16'h0000);
    @(negedge ui_clk);
    checkOutput("both_rdy_after_pair", {app_rdy, app_wdf_rdy}, 2'b11);
    waitCycle();
    wr(28'h000008, BEEF, 16'hFFF0);
    rd(28'h000008, MERGED8, 1'b1, acc);
    waitDrain();

    // Data leads its command by 3 cycles.
    applyStimulus(1'b0, 3'b000, '0, 1'b1, D16, 16'h0000, 1'b0, '0, acc);
    for (int k = 0; k < 3; k++) begin
      @(negedge ui_clk);
      checkOutput("wdf_rdy_held_by_data", {app_wdf_rdy, app_rdy}, 2'b01);
      waitCycle();
    end
    applyStimulus(1'b1, 3'b000, 28'h000010, 1'b0, '0, '0, 1'b0, '0, acc);
    rd(28'h000010, D16, 1'b1, acc);

    // Command leads its data by 2 cycles.
    applyStimulus(1'b1, 3'b000, 28'h000018, 1'b0, '0, '0, 1'b0, '0, acc);
    for (int k = 0; k < 2; k++) begin
      @(negedge ui_clk);
      checkOutput("rdy_held_by_cmd", {app_rdy, app_wdf_rdy}, 2'b01);
      waitCycle();
    end
    applyStimulus(1'b0, 3'b000, '0, 1'b1, D24, 16'h0000, 1'b0, '0, acc);
    @(negedge ui_clk);
    checkOutput("rdy_after_data", app_rdy, 1'b1);
    waitCycle();
    rd(28'h000018, D24, 1'b1, acc);
    waitDrain();

    // Back-to-back reads, one per cycle.
    rd(28'h000000, D0, 1'b1, a[0]);
    rd(28'h000008, MERGED8, 1'b1, a[1]);
    rd(28'h000010, D16, 1'b1, a[2]);
    rd(28'h000018, D24, 1'b1, a[3]);
    for (int k = 1; k < 4; k++) checkOutput($sformatf("b2b_accept%0d", k), a[k] - a[0], k);
    waitDrain();

    // Refresh stall occupies cycles 272..279 after reset release.
    checkOutput("stall_window_reachable", cyc <= rel + 270, 1'b1);
    while (cyc < rel + 270) waitCycle();
    app_en   = 1'b1;
    app_cmd  = 3'b001;
    app_addr = 28'h000000;
    for (int k = 270; k <= 281; k++) begin
      @(negedge ui_clk);
      exp_rdy = !(cyc >= rel + 272 && cyc <= rel + 279);
      checkOutput($sformatf("refresh_rdy_c%0d", cyc - rel), app_rdy, exp_rdy);
      if (app_rdy) exp_q.push_back('{D0, cyc + RD_LAT});
      waitCycle();
    end
    app_en = 1'b0;
    waitDrain();

    // Illegal command with a write beat waiting: nothing may be written.
    @(negedge ui_clk);
    checkOutput("cmd_err_clear", cmd_err, 1'b0);
    waitCycle();
    applyStimulus(1'b0, 3'b000, '0, 1'b1, DX, 16'h0000, 1'b0, '0, acc);
    applyStimulus(1'b1, 3'b111, 28'h000008, 1'b0, '0, '0, 1'b0, '0, acc);
    @(negedge ui_clk);
    checkOutput("cmd_err_set", cmd_err, 1'b1);
    waitCycle();
    rd(28'h000008, MERGED8, 1'b1, acc);
    waitDrain();

    // Reset with two reads in flight: neither may return.
    rd(28'h000000, '0, 1'b0, acc);
    rd(28'h000008, '0, 1'b0, acc);
    reset_n = 1'b0;
    @(negedge ui_clk);
    checkOutput("midreset_outputs", {app_rdy, app_wdf_rdy, app_rd_data_valid,
                                     init_calib_complete, cmd_err}, 5'b0);
    waitCycle();
    waitCycle();
    reset_n = 1'b1;
    rel = cyc;
    calibCheck();
    rd(28'h000008, MERGED8, 1'b1, acc);
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
